// File: rtl/key_debounce_pulse.sv
// Push-button front end: two-flop synchroniser, stability-count debounce FSM,
// registered press/release strobes and a wrapping 8-bit count of accepted presses.
module key_debounce_pulse #(
    parameter int CNT_MAX    = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       KEY_IN,
    output logic       KEY_LEVEL,
    output logic       KEY_RISE,
    output logic       KEY_FALL,
    output logic [7:0] PRESS_CNT
);

    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic IDLE_PIN = ACTIVE_LOW;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic          sync1_q;
    logic          sync2_q;
    logic          pressed;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          rise_q;
    logic          fall_q;
    logic [7:0]    pressCnt_q;
    logic [7:0]    pressCnt_d;

    // Only sync1_q may go metastable; the FSM sees sync2_q alone.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            sync1_q <= IDLE_PIN;
            sync2_q <= IDLE_PIN;
        end else begin
            sync1_q <= KEY_IN;
            sync2_q <= sync1_q;
        end
    end

    assign pressed    = sync2_q ^ IDLE_PIN;
    assign cnt_d      = cnt_q + CNT_ONE;
    assign pressCnt_d = pressCnt_q + 8'd1;

    // Both strobes default low each edge, so a strobe lasts one cycle and a
    // reset simply drops any strobe that would otherwise have fired.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            level_q    <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            pressCnt_q <= 8'd0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pressed) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q    <= PRESSED;
                        cnt_q      <= '0;
                        level_q    <= 1'b1;
                        rise_q     <= 1'b1;
                        pressCnt_q <= pressCnt_d;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                PRESSED: begin
                    if (!pressed) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (pressed) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign KEY_LEVEL = level_q;
    assign KEY_RISE  = rise_q;
    assign KEY_FALL  = fall_q;
    assign PRESS_CNT = pressCnt_q;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Directed bench for key_debounce_pulse: one instance with defaults (CNT_MAX=4, active-low)
// and one with CNT_MAX=2, active-high, driven from a single linear sequence.
module tb_key_debounce_pulse;

    logic       clk;
    logic       rstN;
    logic       keyA;
    logic       keyB;
    logic       levelA, riseA, fallA;
    logic [7:0] cntA;
    logic       levelB, riseB, fallB;
    logic [7:0] cntB;

    int checks;
    int failures;
    int riseCount;
    int fallCount;
    int overlapCount;
    int riseBase;
    int fallBase;

    key_debounce_pulse dutA (
        .CLK       (clk),
        .RST_n     (rstN),
        .KEY_IN    (keyA),
        .KEY_LEVEL (levelA),
        .KEY_RISE  (riseA),
        .KEY_FALL  (fallA),
        .PRESS_CNT (cntA)
    );

    key_debounce_pulse #(.CNT_MAX(2), .ACTIVE_LOW(1'b0)) dutB (
        .CLK       (clk),
        .RST_n     (rstN),
        .KEY_IN    (keyB),
        .KEY_LEVEL (levelB),
        .KEY_RISE  (riseB),
        .KEY_FALL  (fallB),
        .PRESS_CNT (cntB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobes of the default instance are tallied on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (riseA) riseCount++;
        if (fallA) fallCount++;
        if (riseA && fallA) overlapCount++;
    end

    task automatic applyStimulus(input logic newKeyA, input logic newKeyB, input int cycles);
        keyA = newKeyA;
        keyB = newKeyB;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        riseCount    = 0;
        fallCount    = 0;
        overlapCount = 0;
        rstN         = 1'b0;
        keyA         = 1'b1;
        keyB         = 1'b0;

        // Reset values
        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("reset_level", 32'(levelA), 32'd0);
        checkOutput("reset_rise", 32'(riseA), 32'd0);
        checkOutput("reset_fall", 32'(fallA), 32'd0);
        checkOutput("reset_cnt", 32'(cntA), 32'd0);
        checkOutput("reset_cntB", 32'(cntB), 32'd0);
        rstN = 1'b1;
        applyStimulus(1'b1, 1'b0, 3);

        // Clean press: E0 is the first edge after driving; strobe lands on E0+5
        $display("[TB] clean press");
        applyStimulus(1'b0, 1'b0, 5);
        checkOutput("press_rise_early", 32'(riseA), 32'd0);
        checkOutput("press_level_early", 32'(levelA), 32'd0);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("press_rise", 32'(riseA), 32'd1);
        checkOutput("press_level", 32'(levelA), 32'd1);
        checkOutput("press_cnt", 32'(cntA), 32'd1);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("press_rise_drop", 32'(riseA), 32'd0);
        checkOutput("press_level_hold", 32'(levelA), 32'd1);

        // Three-cycle release glitch is rejected, then a clean release
        $display("[TB] glitch and release");
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 8);
        checkOutput("glitch_level", 32'(levelA), 32'd1);
        checkOutput("glitch_fall_count", 32'(fallCount), 32'd0);
        applyStimulus(1'b1, 1'b0, 5);
        checkOutput("release_fall_early", 32'(fallA), 32'd0);
        checkOutput("release_level_early", 32'(levelA), 32'd1);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("release_fall", 32'(fallA), 32'd1);
        checkOutput("release_level", 32'(levelA), 32'd0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("release_fall_drop", 32'(fallA), 32'd0);
        applyStimulus(1'b1, 1'b0, 4);

        // Bouncing press: only the final stable stretch is accepted
        $display("[TB] bounce");
        riseBase = riseCount;
        applyStimulus(1'b0, 1'b0, 2);
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 2);
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 5);
        checkOutput("bounce_no_rise_yet", 32'(riseCount - riseBase), 32'd0);
        checkOutput("bounce_level_early", 32'(levelA), 32'd0);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("bounce_rise", 32'(riseA), 32'd1);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("bounce_rise_count", 32'(riseCount - riseBase), 32'd1);
        checkOutput("bounce_cnt", 32'(cntA), 32'd2);
        applyStimulus(1'b1, 1'b0, 10);
        checkOutput("bounce_released", 32'(levelA), 32'd0);

        // Reset mid-filter (PRESS_WAIT, cnt=2) then a fresh full latency
        $display("[TB] reset mid-filter");
        riseBase = riseCount;
        applyStimulus(1'b0, 1'b0, 4);
        rstN = 1'b0;
        applyStimulus(1'b0, 1'b0, 1);
        rstN = 1'b1;
        checkOutput("midrst_level", 32'(levelA), 32'd0);
        checkOutput("midrst_rise", 32'(riseA), 32'd0);
        checkOutput("midrst_cnt", 32'(cntA), 32'd0);
        applyStimulus(1'b0, 1'b0, 5);
        checkOutput("midrst_no_rise", 32'(riseCount - riseBase), 32'd0);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("midrst_rise_late", 32'(riseA), 32'd1);
        checkOutput("midrst_cnt_after", 32'(cntA), 32'd1);
        applyStimulus(1'b1, 1'b0, 10);

        // Wrap: clear the counter, then 256 clean press/release cycles
        $display("[TB] wrap");
        rstN = 1'b0;
        applyStimulus(1'b1, 1'b0, 1);
        rstN = 1'b1;
        applyStimulus(1'b1, 1'b0, 2);
        riseBase = riseCount;
        fallBase = fallCount;
        for (int i = 0; i < 255; i++) begin
            applyStimulus(1'b0, 1'b0, 8);
            applyStimulus(1'b1, 1'b0, 8);
        end
        checkOutput("wrap_cnt_255", 32'(cntA), 32'd255);
        applyStimulus(1'b0, 1'b0, 8);
        applyStimulus(1'b1, 1'b0, 8);
        checkOutput("wrap_cnt_0", 32'(cntA), 32'd0);
        checkOutput("wrap_rise_count", 32'(riseCount - riseBase), 32'd256);
        checkOutput("wrap_fall_count", 32'(fallCount - fallBase), 32'd256);
        checkOutput("strobe_overlap", 32'(overlapCount), 32'd0);

        // Active-high instance, CNT_MAX=2: strobe lands on E0+3
        $display("[TB] active-high CNT_MAX=2");
        applyStimulus(1'b1, 1'b1, 3);
        checkOutput("b_rise_early", 32'(riseB), 32'd0);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("b_rise", 32'(riseB), 32'd1);
        checkOutput("b_level", 32'(levelB), 32'd1);
        checkOutput("b_cnt", 32'(cntB), 32'd1);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("b_rise_drop", 32'(riseB), 32'd0);
        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("b_fall_early", 32'(fallB), 32'd0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("b_fall", 32'(fallB), 32'd1);
        checkOutput("b_level_low", 32'(levelB), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
